bmr_tdee_qsys_pio_key: RTL and testbench
========================================

Name: bmr_tdee_qsys_pio_key

Overview:
- Avalon-MM slave input PIO: the input-direction counterpart of the LED output PIO.
- Brings external push-buttons/switches into the Nios II subsystem. Each bit is synchronised, debounced and edge-detected.
- Edge events are latched into a capture register, and a maskable level IRQ is raised.
- Sits on the same system interconnect as the LED PIO, with the same zero-wait-state register access.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000, clk cycles between debounce sample ticks (>=1; 50000 = 1 ms at 50 MHz).
- EDGE_TYPE, 1, 0 = rising, 1 = falling, 2 = any edge captured.
- IDLE_LEVEL, 1, reset value of the synchroniser, sample and debounced registers, per bit (all bits = this value).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  word address of register.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  read data, combinational from address.
- irq  output  1  interrupt request, active high, level.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low; all flops clear on its falling edge, independent of clk.
- Reset values:
  - sync1, sync2, samp, db and db_prev = {WIDTH{IDLE_LEVEL}}.
  - mask = 0, capture = 0, prescaler = 0.
  - irq = 0.
  - readdata reflects the reset register contents.
- Synchroniser: two-flop chain per bit, in_port -> sync1 -> sync2, updated every cycle.
- Prescaler:
  - Counts 0..DEBOUNCE_CYCLES-1 and wraps to 0.
  - tick = 1 for the single cycle where count == DEBOUNCE_CYCLES-1.
  - DEBOUNCE_CYCLES = 1 gives tick = 1 every cycle.
- Debounce, on tick only, per bit:
  - samp <= sync2.
  - if sync2 == samp then db <= sync2, else db holds.
  - Net effect: a level must be seen on two consecutive ticks to be accepted.
  - Pulses shorter than one tick period are rejected.
- Latency: from an in_port change to the db change is 2 cycles of sync plus 1 to 2 tick periods.
- Edge detect:
  - db_prev <= db every cycle.
  - rising = db & ~db_prev; falling = ~db & db_prev.
  - edge = the term selected by EDGE_TYPE (for 2: rising | falling).
- Capture register:
  - Each cycle: capture <= (capture & ~clr) | edge.
  - clr = writedata[WIDTH-1:0] when chipselect && ~write_n && address == 3, else 0.
  - An edge arriving in the same cycle as a clear of the same bit sets the bit: a new event wins and is never lost.
  - Edges are captured regardless of mask.
- Mask register: written from writedata[WIDTH-1:0] when chipselect && ~write_n && address == 2.
- Writes to address 0 or 1 are ignored.
- irq = |(capture & mask), driven from flops. It deasserts the cycle after the clearing write, unless a new edge is captured in that same cycle.
- Reads, combinational, zero wait, upper bits zero-extended. chipselect is not required for readdata.
  - address 0: db.
  - address 1: 0 (direction register, fixed input).
  - address 2: mask.
  - address 3: capture.
- Reading has no side effects.
- Reset mid-bounce: all state returns to IDLE_LEVEL, so no spurious edge is captured on reset release while inputs are at idle level.

Test Plan:
- Reset, then in_port = 4'b1111 held; read addresses 0..3 -> 0x0000000F, 0x0, 0x0, 0x0; irq = 0.
- DEBOUNCE_CYCLES = 4, EDGE_TYPE = 1:
  - Drive in_port[2] low for 20 cycles -> db[2] = 0 within 2+8 cycles; capture = 0x4; irq = 0 (mask = 0).
  - Then write mask = 0x4 -> irq = 1 the next cycle.
- Glitch rejection: DEBOUNCE_CYCLES = 4; pulse in_port[0] low for 2 cycles -> db and capture unchanged; irq = 0.
- Clear collision:
  - With capture = 0x4, write 0x4 to address 3 in the same cycle a new falling edge on bit 2 is generated -> capture stays 0x4; irq stays 1.
  - A plain clear with no new edge -> capture = 0; irq = 0 the next cycle.
- EDGE_TYPE = 2: press and release bit 1 -> capture[1] set on the press. Clear it; the release sets it again.
- Assert reset_n = 0 mid-debounce with capture = 0xF and mask = 0xF -> irq = 0 and all registers at reset values asynchronously; no capture after release with inputs at 1111.

Source files
------------

// File: rtl/bmr_tdee_qsys_pio_key.sv
// bmr_tdee_qsys_pio_key: Avalon-MM input PIO with per-bit sync, debounce,
// edge capture and a maskable level interrupt.
module bmr_tdee_qsys_pio_key #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1,
    parameter int IDLE_LEVEL      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int PW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [WIDTH-1:0] L_IDLE = IDLE_LEVEL != 0 ? '1 : '0;

    logic [WIDTH-1:0] r_sync1, r_sync2, r_samp, r_db, r_db_prev, r_mask, r_cap;
    logic [PW-1:0]    r_cnt;
    logic             w_tick, w_wr, w_unused;
    logic [WIDTH-1:0] w_rise, w_fall, w_edge, w_clr;

    assign w_tick   = r_cnt == PW'(DEBOUNCE_CYCLES - 1);
    assign w_wr     = chipselect & ~write_n;
    assign w_clr    = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign w_rise   = r_db & ~r_db_prev;
    assign w_fall   = ~r_db & r_db_prev;
    assign w_edge   = EDGE_TYPE == 0 ? w_rise : EDGE_TYPE == 1 ? w_fall : (w_rise | w_fall);
    assign irq      = |(r_cap & r_mask);
    assign w_unused = ^writedata;

    always_comb begin
        readdata = address == 2'd0 ? 32'(r_db)   :
                   address == 2'd2 ? 32'(r_mask) :
                   address == 2'd3 ? 32'(r_cap)  : 32'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= L_IDLE;
            r_sync2   <= L_IDLE;
            r_samp    <= L_IDLE;
            r_db      <= L_IDLE;
            r_db_prev <= L_IDLE;
            r_mask    <= '0;
            r_cap     <= '0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= in_port;
            r_sync2   <= r_sync1;
            r_cnt     <= w_tick ? '0 : r_cnt + PW'(1);
            // a level is accepted only once two consecutive ticks agree
            if (w_tick) begin
                r_samp <= r_sync2;
                if (r_sync2 == r_samp) r_db <= r_sync2;
            end
            r_db_prev <= r_db;
            r_cap     <= (r_cap & ~w_clr) | w_edge;
            if (w_wr && address == 2'd2) r_mask <= writedata[WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_bmr_tdee_qsys_pio_key.sv
// tb_bmr_tdee_qsys_pio_key: vector table plus directed sequences, reads
// checked through an expected-value queue.
module tb_bmr_tdee_qsys_pio_key;
    logic        clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
    logic [1:0]  address = 0;
    logic [31:0] writedata = 0, rd_f, rd_a;
    logic [3:0]  in_f = 4'hF, in_a = 4'hF;
    logic        irq_f, irq_a;
    int          n_chk = 0, n_err = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    bmr_tdee_qsys_pio_key #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_f), .readdata(rd_f), .irq(irq_f));

    bmr_tdee_qsys_pio_key #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .IDLE_LEVEL(1)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a));

    typedef struct {
        logic        we;
        logic [1:0]  wa;
        logic [31:0] wd;
        logic [1:0]  ra;
        logic [31:0] exp;
        logic        exp_irq;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1; write_n = 0;
        @(negedge clk);
        chipselect = 0; write_n = 1;
    endtask

    task automatic rd(input string nm, input bit any, input logic [1:0] a, input logic [31:0] e);
        address = a;
        sb.push_back(e);
        #1;
        chk(nm, any ? rd_a : rd_f, sb.pop_front());
    endtask

    vec_t vt[10];
    bit   found;

    initial begin
        vt[0] = '{0, 0, 0, 0, 32'hF, 0};
        vt[1] = '{0, 0, 0, 1, 32'h0, 0};
        vt[2] = '{0, 0, 0, 2, 32'h0, 0};
        vt[3] = '{0, 0, 0, 3, 32'h0, 0};
        vt[4] = '{1, 2, 32'hFFFF_FFF5, 2, 32'h5, 0};
        vt[5] = '{1, 0, 32'h0, 0, 32'hF, 0};
        vt[6] = '{1, 1, 32'hF, 1, 32'h0, 0};
        vt[7] = '{1, 2, 32'hA, 2, 32'hA, 0};
        vt[8] = '{1, 3, 32'hF, 3, 32'h0, 0};
        vt[9] = '{1, 2, 32'h0, 2, 32'h0, 0};

        cycles(3);
        reset_n = 1;
        cycles(2);
        for (int i = 0; i < 10; i++) begin
            if (vt[i].we) wr(vt[i].wa, vt[i].wd);
            rd($sformatf("vec%0d_rd", i), 0, vt[i].ra, vt[i].exp);
            chk($sformatf("vec%0d_irq", i), 32'(irq_f), 32'(vt[i].exp_irq));
            @(negedge clk);
        end

        // glitch shorter than a tick period is rejected
        in_f[0] = 0; cycles(2); in_f[0] = 1; cycles(12);
        rd("glitch_db", 0, 0, 32'hF);
        rd("glitch_cap", 0, 3, 32'h0);
        chk("glitch_irq", 32'(irq_f), 0);

        // falling edge on bit 2, masked off then enabled
        @(negedge clk);
        in_f[2] = 0; cycles(10);
        rd("fall_db_bound", 0, 0, 32'hB);
        cycles(10);
        rd("fall_cap", 0, 3, 32'h4);
        chk("fall_irq_masked", 32'(irq_f), 0);
        wr(2, 32'h4);
        chk("mask_irq", 32'(irq_f), 1);

        // rising edge ignored, then clear collides with a new falling edge
        in_f[2] = 1; cycles(20);
        rd("rise_ignored", 0, 3, 32'h4);
        @(negedge clk);
        in_f[2] = 0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            address = 0; #1;
            if (rd_f[2] == 0) found = 1; else @(negedge clk);
        end
        chk("collide_wait", 32'(found), 1);
        wr(3, 32'h4);
        rd("collide_cap", 0, 3, 32'h4);
        chk("collide_irq", 32'(irq_f), 1);
        @(negedge clk);
        wr(3, 32'h4);
        rd("clear_cap", 0, 3, 32'h0);
        chk("clear_irq", 32'(irq_f), 0);

        // any-edge instance: press and release both capture
        @(negedge clk);
        in_a[1] = 0; cycles(20);
        rd("any_press", 1, 3, 32'h2);
        wr(3, 32'h2);
        rd("any_clear", 1, 3, 32'h0);
        @(negedge clk);
        in_a[1] = 1; cycles(20);
        rd("any_release", 1, 3, 32'h2);
        rd("any_db", 1, 0, 32'hF);

        // async reset mid-bounce with everything pending
        @(negedge clk);
        in_f = 4'hF; cycles(20);
        wr(3, 32'hF);
        in_f = 4'h0; cycles(20);
        rd("all_cap", 0, 3, 32'hF);
        wr(2, 32'hF);
        chk("all_irq", 32'(irq_f), 1);
        in_f = 4'hF; cycles(5);
        #1 reset_n = 0;
        #1 chk("rst_irq_async", 32'(irq_f), 0);
        rd("rst_cap_async", 0, 3, 32'h0);
        @(negedge clk);
        rd("rst_db", 0, 0, 32'hF);
        rd("rst_mask", 0, 2, 32'h0);
        @(negedge clk);
        reset_n = 1;
        cycles(20);
        rd("post_rst_cap", 0, 3, 32'h0);
        chk("post_rst_irq", 32'(irq_f), 0);
        rd("post_rst_db", 0, 0, 32'hF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
